// File: rtl/jt10_wrseq.sv
`timescale 1ns/1ps
// jt10_wrseq -- register-write sequencer for a YM2610-style chip bus.
//
// Commands {bank, reg, val} are queued in a small FIFO. Each command is
// played out on the chip bus as follows:
//   1. Poll the busy flag.
//   2. Strobe the register number onto the address port.
//   3. Leave a one-cycle gap.
//   4. Strobe the value onto the data port.
// The sequencer advances only on cen edges. The FIFO accepts pushes on
// every clk edge.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   cen             clock enable for the sequencer
//   cmd_valid/ready command handshake (ready = FIFO not full)
//   cmd_bank        0 -> ports 0/1, 1 -> ports 2/3
//   cmd_reg/val     register number and value
//   addr/din/cs_n/wr_n  registered chip bus
//   dout            chip status, bit 7 = busy
//   idle            sequencer idle and FIFO empty
//   timeout         one-clk pulse when a busy wait gave up
module jt10_wrseq #(
  parameter int FIFO_AW = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_bank,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_val,
  output logic [1:0] addr,
  output logic [7:0] din,
  output logic       cs_n,
  output logic       wr_n,
  input  logic [7:0] dout,
  output logic       idle,
  output logic       timeout
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);
  // Value of the wait counter at which one more busy sample expires the wait
  localparam logic [CW-1:0]    WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_ADDR_WR,
    S_GAP,
    S_DATA_WR,
    S_END
  } state_t;

  state_t             state, state_nxt;
  logic [16:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [16:0]        head;
  logic               cur_bank;
  logic [7:0]         cur_reg, cur_val;
  logic [CW-1:0]      wcnt;
  logic               rdy_en;
  logic               push, pop, pop_req, expire, busy, sel_bank;
  logic               cs_nxt, wr_nxt;
  logic [1:0]         addr_nxt;
  logic [7:0]         din_nxt;
  logic               unused_dout;

  assign busy        = dout[7];
  assign unused_dout = ^dout[6:0];
  assign head        = mem[rd_ptr];
  // rdy_en keeps cmd_ready low through reset and until the first clk after it
  assign cmd_ready   = rdy_en & (count != FULL_CNT);
  assign idle        = (state == S_IDLE) & (count == '0);
  assign push        = cmd_valid & cmd_ready;
  assign pop         = cen & pop_req;
  // On entry to POLL the bank comes straight from the FIFO head being popped
  assign sel_bank    = pop_req ? head[16] : cur_bank;

  always_comb begin
    state_nxt = state;
    pop_req   = 1'b0;
    expire    = 1'b0;
    case (state)
      S_IDLE, S_END: begin
        if (count != '0) begin
          pop_req   = 1'b1;
          state_nxt = S_POLL;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_POLL: begin
        if (!busy) begin
          state_nxt = S_ADDR_WR;
        end else if (wcnt == WAIT_LAST) begin
          expire    = 1'b1;
          state_nxt = S_ADDR_WR;
        end
      end
      S_ADDR_WR: state_nxt = S_GAP;
      S_GAP:     state_nxt = S_DATA_WR;
      S_DATA_WR: state_nxt = S_END;
      default:   state_nxt = S_IDLE;
    endcase

    // Bus values for the state being entered; GAP keeps addr/din unchanged
    cs_nxt   = 1'b1;
    wr_nxt   = 1'b1;
    addr_nxt = 2'd0;
    din_nxt  = 8'd0;
    case (state_nxt)
      S_POLL: begin
        cs_nxt   = 1'b0;
        addr_nxt = {sel_bank, 1'b0};
      end
      S_ADDR_WR: begin
        cs_nxt   = 1'b0;
        wr_nxt   = 1'b0;
        addr_nxt = {cur_bank, 1'b0};
        din_nxt  = cur_reg;
      end
      S_GAP: begin
        addr_nxt = addr;
        din_nxt  = din;
      end
      S_DATA_WR: begin
        cs_nxt   = 1'b0;
        wr_nxt   = 1'b0;
        addr_nxt = {cur_bank, 1'b1};
        din_nxt  = cur_val;
      end
      default: ;
    endcase
  end

  // ---- stage: command FIFO (push on any clk, pop on cen) ----
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_bank, cmd_reg, cmd_val};
    if (pop) begin
      cur_bank <= head[16];
      cur_reg  <= head[15:8];
      cur_val  <= head[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // ---- stage: sequencer state, wait counter and registered bus ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      cs_n    <= 1'b1;
      wr_n    <= 1'b1;
      addr    <= 2'd0;
      din     <= 8'd0;
      timeout <= 1'b0;
    end else begin
      // Not gated by cen so the pulse is always exactly one clk wide
      timeout <= cen & expire;
      if (cen) begin
        state <= state_nxt;
        // Counts busy samples while staying in POLL; zero everywhere else
        wcnt  <= (state == S_POLL && state_nxt == S_POLL) ? wcnt + 1'b1 : '0;
        cs_n  <= cs_nxt;
        wr_n  <= wr_nxt;
        addr  <= addr_nxt;
        din   <= din_nxt;
      end
    end
  end

endmodule

// File: tb/tb_jt10_wrseq.sv
`timescale 1ns/1ps
// Testbench for jt10_wrseq: directed command sequences checked against a
// write scoreboard (each command expects an address write then a data write)
// plus per-cycle bus rule checks and hand-computed cycle tables.
module tb_jt10_wrseq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cen = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_bank = 1'b0;
  logic [7:0] cmd_reg = 8'd0;
  logic [7:0] cmd_val = 8'd0;
  logic [1:0] addr;
  logic [7:0] din;
  logic       cs_n;
  logic       wr_n;
  logic [7:0] dout = 8'd0;
  logic       idle;
  logic       timeout;

  jt10_wrseq #(.FIFO_AW(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_bank(cmd_bank), .cmd_reg(cmd_reg), .cmd_val(cmd_val),
    .addr(addr), .din(din), .cs_n(cs_n), .wr_n(wr_n),
    .dout(dout), .idle(idle), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected chip writes in order: {addr[1:0], data[7:0]}
  logic [9:0] exp_q[$];

  int   cen_period = 0;
  int   cen_ph = 0;
  int   wr_w = 0, to_w = 0, to_pulses = 0, poll_clk = 0, quiet = 0, bus_act = 0;
  logic wr_prev = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_cen(input int p);
    cen_period = p;
    cen_ph = 0;
    cen = (p != 0);
  endtask

  task automatic clr();
    poll_clk = 0;
    quiet = 0;
    bus_act = 0;
    to_pulses = 0;
  endtask

  task automatic push(input logic b, input logic [7:0] r, input logic [7:0] v);
    bit acc = 1'b0;
    cmd_bank = b;
    cmd_reg = r;
    cmd_val = v;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = cmd_ready;
      @(posedge clk);
    end
    if (acc) begin
      exp_q.push_back({b, 1'b0, r});
      exp_q.push_back({b, 1'b1, v});
    end else begin
      checks++;
      errors++;
      $display("FAIL push_accept: got ready=0 for 100 clk, expected ready=1");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    bit got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge clk);
      if (idle) got = 1'b1;
    end
    check("wait_idle", int'(got), 1);
  endtask

  // Clock enable generator for the every-third-clk mode
  initial forever begin
    @(negedge clk);
    if (cen_period == 3) begin
      cen_ph = (cen_ph + 1) % 3;
      cen = (cen_ph == 0);
    end
  end

  // Compare process: bus rules and scoreboard on every clk
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      wr_prev = 1'b1;
      wr_w = 0;
      to_w = 0;
    end else begin
      check("wr_without_cs", int'(!wr_n && cs_n), 0);
      if (!cs_n) bus_act++;
      if (!cs_n && wr_n) poll_clk++;
      if (cs_n && wr_n && addr == 2'd0 && din == 8'd0 && !idle) quiet++;
      if (!wr_n) begin
        if (wr_prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr=%0d din=0x%0h, expected no write", addr, din);
          end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            check("write_addr", int'(addr), int'(e[9:8]));
            check("write_data", int'(din), int'(e[7:0]));
          end
        end
        wr_w++;
      end else if (!wr_prev) begin
        check("wr_width", wr_w, (cen_period == 3) ? 3 : 1);
        wr_w = 0;
      end
      if (timeout) to_w++;
      else if (to_w > 0) begin
        check("timeout_width", to_w, 1);
        to_pulses++;
        to_w = 0;
      end
      wr_prev = wr_n;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int t_cs[6]   = '{0, 0, 1, 0, 1, 1};
  int t_wr[6]   = '{1, 0, 1, 0, 1, 1};
  int t_addr[6] = '{0, 0, 0, 1, 0, 0};
  int t_din[6]  = '{'h00, 'h28, 'h28, 'hF1, 'h00, 'h00};
  int t_idle[6] = '{0, 0, 0, 0, 0, 1};

  initial begin
    // Reset values appear without any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_wr_n", int'(wr_n), 1);
    check("rst_addr", int'(addr), 0);
    check("rst_din", int'(din), 0);
    check("rst_idle", int'(idle), 1);
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_timeout", int'(timeout), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_clk", int'(cmd_ready), 0);
    @(negedge clk);
    check("ready_after_clk", int'(cmd_ready), 1);

    // Single write, bus traced cycle by cycle
    set_cen(1);
    clr();
    push(1'b0, 8'h28, 8'hF1);
    check("t1_idle_after_push", int'(idle), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("t1_cs_n_%0d", i), int'(cs_n), t_cs[i]);
      check($sformatf("t1_wr_n_%0d", i), int'(wr_n), t_wr[i]);
      check($sformatf("t1_addr_%0d", i), int'(addr), t_addr[i]);
      check($sformatf("t1_din_%0d", i), int'(din), t_din[i]);
      check($sformatf("t1_idle_%0d", i), int'(idle), t_idle[i]);
    end
    check("t1_drain", exp_q.size(), 0);

    // Busy for three samples, then ready
    clr();
    push(1'b0, 8'hA4, 8'h22);
    dout = 8'h80;
    repeat (4) @(negedge clk);
    dout = 8'h00;
    wait_idle(40);
    check("t2_poll_clk", poll_clk, 4);
    check("t2_timeouts", to_pulses, 0);
    check("t2_drain", exp_q.size(), 0);

    // Busy stuck: wait expires after 4 samples
    clr();
    dout = 8'h80;
    push(1'b1, 8'hB4, 8'hC0);
    wait_idle(40);
    dout = 8'h00;
    @(negedge clk);
    check("t3_poll_clk", poll_clk, 4);
    check("t3_timeouts", to_pulses, 1);
    check("t3_drain", exp_q.size(), 0);

    // Fill the FIFO while frozen, then five back-to-back commands on bank 1
    set_cen(0);
    clr();
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 8'(8'h30 + i), 8'(8'h10 + i));
      check($sformatf("t4_ready_%0d", i), int'(cmd_ready), (i < 3) ? 1 : 0);
    end
    check("t4_frozen_cs", int'(cs_n), 1);
    check("t4_frozen_idle", int'(idle), 0);
    set_cen(1);
    @(posedge clk);
    #1 clr();
    push(1'b1, 8'h34, 8'h14);
    wait_idle(80);
    check("t4_poll_clk", poll_clk, 5);
    check("t4_end_only", quiet, 5);
    check("t4_drain", exp_q.size(), 0);

    // cen every third clk
    set_cen(3);
    clr();
    push(1'b0, 8'h40, 8'h55);
    push(1'b1, 8'hA0, 8'h3C);
    wait_idle(200);
    check("t5_poll_clk", poll_clk, 6);
    check("t5_drain", exp_q.size(), 0);
    clr();
    dout = 8'h80;
    push(1'b0, 8'h2B, 8'h80);
    wait_idle(200);
    dout = 8'h00;
    @(negedge clk);
    check("t5_to_poll_clk", poll_clk, 12);
    check("t5_timeouts", to_pulses, 1);
    check("t5_to_drain", exp_q.size(), 0);

    // Reset during DATA_WR with two commands still queued
    set_cen(0);
    clr();
    push(1'b0, 8'h50, 8'h01);
    push(1'b0, 8'h51, 8'h02);
    push(1'b0, 8'h52, 8'h03);
    set_cen(1);
    begin
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
        @(posedge clk);
        #1;
        if (!wr_n && addr == 2'd1) found = 1'b1;
      end
      check("t6_found_data_wr", int'(found), 1);
    end
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t6_rst_cs_n", int'(cs_n), 1);
    check("t6_rst_wr_n", int'(wr_n), 1);
    check("t6_rst_addr", int'(addr), 0);
    check("t6_rst_din", int'(din), 0);
    check("t6_rst_idle", int'(idle), 1);
    check("t6_rst_ready", int'(cmd_ready), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clr();
    repeat (25) @(negedge clk);
    check("t6_no_activity", bus_act, 0);
    check("t6_idle", int'(idle), 1);
    check("t6_ready", int'(cmd_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
